credential_sender: RTL and testbench

//  Drives the Authentication digit interface (UserDigit/UserLoad) from a latched 4-digit ID and 6-digit password.

---
 rtl/credential_sender.sv | 194 +++++++++++++++++++
 tb/tb_credential_sender.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/credential_sender.sv
// credential_sender: plays a latched 4-digit ID and 6-digit password into Authentication, then tracks login/logout.
// Optional macro CRED_SENDER_RETRY_EN: replay the latched credential once after the first login timeout.
module credential_sender #(
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int ID_PW_GAP = 70,
  parameter int LOGIN_TMO = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] id_in,
  input  logic [23:0] pswd_in,
  input  logic        logout_req,
  input  logic        LoggedIn,
  input  logic [2:0]  PlayerID_from_pswd,
  output logic [3:0]  UserDigit,
  output logic        UserLoad,
  output logic        logout_from_gamectrl,
  output logic        busy,
  output logic        logged_in,
  output logic [2:0]  player_id,
  output logic        fail
);

  localparam int SLOT_LEN = SETUP_CYC + 1 + HOLD_CYC;
  localparam int SW       = $clog2(SLOT_LEN);
  localparam int GW       = $clog2(ID_PW_GAP + 1);
  localparam int TW       = $clog2(LOGIN_TMO + 1);

  typedef enum logic [2:0] {
    IDLE, ID_SEND, ID_GAP, PW_SEND, WAIT_LOGIN, LOGGED, LOGOUT, FAIL
  } state_t;

  state_t       state;
  logic [15:0]  idShift;
  logic [23:0]  pwShift;
  logic [SW-1:0] slotCnt;
  logic [2:0]   digitIdx;
  logic [GW-1:0] gapCnt;
  logic [TW-1:0] tmoCnt;
  logic         slotLast;

`ifdef CRED_SENDER_RETRY_EN
  // Shift registers are consumed while sending; these copies feed the replay.
  logic [15:0]  idLatch;
  logic [23:0]  pwLatch;
  logic         retried;
`endif

  assign slotLast = (slotCnt == SW'(SLOT_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      idShift              <= '0;
      pwShift              <= '0;
      slotCnt              <= '0;
      digitIdx             <= '0;
      gapCnt               <= '0;
      tmoCnt               <= '0;
      UserDigit            <= '0;
      UserLoad             <= 1'b0;
      logout_from_gamectrl <= 1'b0;
      busy                 <= 1'b0;
      logged_in            <= 1'b0;
      player_id            <= '0;
      fail                 <= 1'b0;
`ifdef CRED_SENDER_RETRY_EN
      idLatch              <= '0;
      pwLatch              <= '0;
      retried              <= 1'b0;
`endif
    end else begin
      UserLoad             <= 1'b0;
      logout_from_gamectrl <= 1'b0;
      case (state)
        IDLE, FAIL: begin
          if (start) begin
            idShift   <= id_in;
            pwShift   <= pswd_in;
            slotCnt   <= '0;
            digitIdx  <= '0;
            fail      <= 1'b0;
            player_id <= '0;
            busy      <= 1'b1;
            state     <= ID_SEND;
`ifdef CRED_SENDER_RETRY_EN
            idLatch   <= id_in;
            pwLatch   <= pswd_in;
            retried   <= 1'b0;
`endif
          end
        end

        ID_SEND: begin
          if (slotCnt == '0) UserDigit <= idShift[15:12];
          UserLoad <= (slotCnt == SW'(SETUP_CYC));
          if (slotLast) begin
            slotCnt <= '0;
            idShift <= {idShift[11:0], 4'h0};
            if (digitIdx == 3'd3) begin
              digitIdx <= '0;
              gapCnt   <= '0;
              state    <= ID_GAP;
            end else begin
              digitIdx <= digitIdx + 3'd1;
            end
          end else begin
            slotCnt <= slotCnt + SW'(1);
          end
        end

        ID_GAP: begin
          UserDigit <= '0;
          if (gapCnt == GW'(ID_PW_GAP - 1)) begin
            state <= PW_SEND;
          end else begin
            gapCnt <= gapCnt + GW'(1);
          end
        end

        PW_SEND: begin
          if (slotCnt == '0) UserDigit <= pwShift[23:20];
          UserLoad <= (slotCnt == SW'(SETUP_CYC));
          if (slotLast) begin
            slotCnt <= '0;
            pwShift <= {pwShift[19:0], 4'h0};
            if (digitIdx == 3'd5) begin
              digitIdx <= '0;
              tmoCnt   <= '0;
              state    <= WAIT_LOGIN;
            end else begin
              digitIdx <= digitIdx + 3'd1;
            end
          end else begin
            slotCnt <= slotCnt + SW'(1);
          end
        end

        WAIT_LOGIN: begin
          UserDigit <= '0;
          // LoggedIn takes priority over a coincident timeout.
          if (LoggedIn) begin
            player_id <= PlayerID_from_pswd;
            logged_in <= 1'b1;
            busy      <= 1'b0;
            state     <= LOGGED;
          end else if (tmoCnt == TW'(LOGIN_TMO - 1)) begin
`ifdef CRED_SENDER_RETRY_EN
            if (!retried) begin
              retried  <= 1'b1;
              idShift  <= idLatch;
              pwShift  <= pwLatch;
              slotCnt  <= '0;
              digitIdx <= '0;
              state    <= ID_SEND;
            end else
`endif
            begin
              fail  <= 1'b1;
              busy  <= 1'b0;
              state <= FAIL;
            end
          end else begin
            tmoCnt <= tmoCnt + TW'(1);
          end
        end

        LOGGED: begin
          if (logout_req) begin
            logout_from_gamectrl <= 1'b1;
            logged_in            <= 1'b0;
            busy                 <= 1'b1;
            state                <= LOGOUT;
          end else if (!LoggedIn) begin
            logged_in <= 1'b0;
            state     <= IDLE;
          end
        end

        LOGOUT: begin
          if (!LoggedIn) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_credential_sender.sv
// Self-checking bench for credential_sender: random credentials checked against a timing/digit model
// derived from slot, gap and timeout arithmetic.
module tb_credential_sender;

  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int GAP   = 70;
  localparam int TMO   = 64;
  localparam int SLOT  = SETUP + 1 + HOLD;
  localparam int SEQ   = 10 * SLOT + GAP;
`ifdef CRED_SENDER_RETRY_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, logout_req = 1'b0, LoggedIn = 1'b0;
  logic [15:0] id_in = '0;
  logic [23:0] pswd_in = '0;
  logic [2:0]  PlayerID = '0;
  logic [3:0]  UserDigit;
  logic        UserLoad, logout_from_gamectrl, busy, logged_in, fail;
  logic [2:0]  player_id;

  int checks = 0, failures = 0;
  int cyc = 0, dblLoad = 0, logoutCnt = 0;
  logic prevLoad = 1'b0;
  int         pT[$];
  logic [3:0] pD[$];
  int         eT[$];
  logic [3:0] eD[$];

  credential_sender #(
    .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .ID_PW_GAP(GAP), .LOGIN_TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .id_in(id_in), .pswd_in(pswd_in),
    .logout_req(logout_req), .LoggedIn(LoggedIn), .PlayerID_from_pswd(PlayerID),
    .UserDigit(UserDigit), .UserLoad(UserLoad), .logout_from_gamectrl(logout_from_gamectrl),
    .busy(busy), .logged_in(logged_in), .player_id(player_id), .fail(fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every digit strobe with the index of the edge that produced it.
  always @(negedge clk) begin
    if (rst && UserLoad) begin
      pT.push_back(cyc);
      pD.push_back(UserDigit);
    end
    if (UserLoad && prevLoad) dblLoad <= dblLoad + 1;
    prevLoad <= UserLoad;
    if (logout_from_gamectrl) logoutCnt <= logoutCnt + 1;
  end

  function automatic void build_expected(int e, logic [15:0] id, logic [23:0] pw, int passes);
    eT.delete();
    eD.delete();
    for (int p = 0; p < passes; p++) begin
      int b;
      b = e + p * (SEQ + TMO);
      for (int k = 0; k < 4; k++) begin
        eT.push_back(b + 1 + SETUP + k * SLOT);
        eD.push_back(id[15 - 4 * k -: 4]);
      end
      for (int j = 0; j < 6; j++) begin
        eT.push_back(b + 1 + SETUP + 4 * SLOT + GAP + j * SLOT);
        eD.push_back(pw[23 - 4 * j -: 4]);
      end
    end
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] id, input logic [23:0] pw, output int e);
    @(negedge clk);
    id_in = id; pswd_in = pw; start = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    start = 1'b0;
    id_in = 16'($urandom); pswd_in = 24'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({UserDigit, UserLoad, logout_from_gamectrl, busy, logged_in, player_id, fail} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {UserDigit, UserLoad, logout_from_gamectrl, busy, logged_in, player_id, fail});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || UserLoad !== 1'b0) begin
      failures++; $display("FAIL reset_idle: got busy=%b load=%b expected 0 0", busy, UserLoad);
    end
  endtask

  task automatic test_login(input logic [15:0] id, input logic [23:0] pw, input logic [2:0] pid, input int r);
    int e, base;
    base = pT.size();
    do_start(id, pw, e);
    build_expected(e, id, pw, 1);
    wait_until(e + 5);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL login_busy: got %b expected 1", busy); end
    wait_until(e + 50);
    checks++;
    if (UserDigit !== 4'h0) begin failures++; $display("FAIL login_gap_digit: got %h expected 0", UserDigit); end
    wait_until(e + SEQ + r);
    checks++;
    if (logged_in !== 1'b0) begin failures++; $display("FAIL login_early: got %b expected 0", logged_in); end
    LoggedIn = 1'b1; PlayerID = pid;
    @(negedge clk);
    checks++;
    if (logged_in !== 1'b1 || busy !== 1'b0 || fail !== 1'b0) begin
      failures++; $display("FAIL login_flags: got li=%b busy=%b fail=%b expected 1 0 0", logged_in, busy, fail);
    end
    checks++;
    if (player_id !== pid) begin failures++; $display("FAIL login_pid: got %0d expected %0d", player_id, pid); end
    checks++;
    if (UserDigit !== 4'h0) begin failures++; $display("FAIL login_digit_idle: got %h expected 0", UserDigit); end
    checks++;
    if (pT.size() - base != eT.size()) begin
      failures++; $display("FAIL login_pulse_count: got %0d expected %0d", pT.size() - base, eT.size());
    end
    for (int i = 0; i < eT.size(); i++) begin
      int gt; logic [3:0] gd;
      gt = (base + i < pT.size()) ? pT[base + i] : -1;
      gd = (base + i < pT.size()) ? pD[base + i] : 4'hx;
      checks++;
      if (gt != eT[i] || gd !== eD[i]) begin
        failures++; $display("FAIL login_pulse[%0d]: got t=%0d d=%h expected t=%0d d=%h", i, gt - e, gd, eT[i] - e, eD[i]);
      end
    end
    checks++;
    if (dblLoad != 0) begin failures++; $display("FAIL load_back_to_back: got %0d expected 0", dblLoad); end
  endtask

  task automatic test_logout(input logic [2:0] pid);
    int lc0, base;
    @(negedge clk);
    lc0 = logoutCnt;
    logout_req = 1'b1;
    @(negedge clk);
    logout_req = 1'b0;
    checks++;
    if (logout_from_gamectrl !== 1'b1 || logged_in !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL logout_enter: got lo=%b li=%b busy=%b expected 1 0 1", logout_from_gamectrl, logged_in, busy);
    end
    @(negedge clk);
    checks++;
    if (logout_from_gamectrl !== 1'b0) begin failures++; $display("FAIL logout_width: got %b expected 0", logout_from_gamectrl); end
    start = 1'b1;
    base = pT.size();
    @(negedge clk);
    start = 1'b0; LoggedIn = 1'b0;
    @(negedge clk);
    checks++;
    if (logged_in !== 1'b0 || busy !== 1'b0 || player_id !== pid) begin
      failures++; $display("FAIL logout_idle: got li=%b busy=%b pid=%0d expected 0 0 %0d", logged_in, busy, player_id, pid);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (pT.size() != base || busy !== 1'b0) begin
      failures++; $display("FAIL logout_start_ignored: got pulses=%0d busy=%b expected 0 0", pT.size() - base, busy);
    end
    checks++;
    if (logoutCnt - lc0 != 1) begin failures++; $display("FAIL logout_count: got %0d expected 1", logoutCnt - lc0); end
  endtask

  task automatic test_timeout();
    logic [15:0] id; logic [23:0] pw;
    int e, base, expF;
    id = 16'($urandom); pw = 24'($urandom);
    base = pT.size();
    do_start(id, pw, e);
    checks++;
    if (player_id !== 3'd0 || busy !== 1'b1 || fail !== 1'b0) begin
      failures++; $display("FAIL timeout_start: got pid=%0d busy=%b fail=%b expected 0 1 0", player_id, busy, fail);
    end
    build_expected(e, id, pw, PASSES);
    expF = e + PASSES * (SEQ + TMO);
    while (fail !== 1'b1 && cyc < expF + 50) @(negedge clk);
    checks++;
    if (cyc != expF) begin
      failures++; $display("FAIL timeout_edge: got fail at E+%0d (fail=%b) expected E+%0d", cyc - e, fail, expF - e);
    end
    checks++;
    if (busy !== 1'b0 || logged_in !== 1'b0 || fail !== 1'b1) begin
      failures++; $display("FAIL timeout_flags: got busy=%b li=%b fail=%b expected 0 0 1", busy, logged_in, fail);
    end
    checks++;
    if (pT.size() - base != eT.size()) begin
      failures++; $display("FAIL timeout_pulse_count: got %0d expected %0d", pT.size() - base, eT.size());
    end
    for (int i = 0; i < eT.size(); i++) begin
      int gt; logic [3:0] gd;
      gt = (base + i < pT.size()) ? pT[base + i] : -1;
      gd = (base + i < pT.size()) ? pD[base + i] : 4'hx;
      checks++;
      if (gt != eT[i] || gd !== eD[i]) begin
        failures++; $display("FAIL timeout_pulse[%0d]: got t=%0d d=%h expected t=%0d d=%h", i, gt - e, gd, eT[i] - e, eD[i]);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [15:0] id; logic [23:0] pw;
    int e, base;
    id = 16'($urandom); pw = 24'($urandom);
    do_start(id, pw, e);
    checks++;
    if (fail !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL restart_from_fail: got fail=%b busy=%b expected 0 1", fail, busy);
    end
    wait_until(e + 1 + 4 * SLOT + GAP + 2 * SLOT + 1);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({UserDigit, UserLoad, logout_from_gamectrl, busy, logged_in, player_id, fail} !== 13'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got %b expected all zero",
               {UserDigit, UserLoad, logout_from_gamectrl, busy, logged_in, player_id, fail});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base = pT.size();
    repeat (20) @(negedge clk);
    checks++;
    if (pT.size() != base || busy !== 1'b0) begin
      failures++; $display("FAIL midreset_quiet: got pulses=%0d busy=%b expected 0 0", pT.size() - base, busy);
    end
    id = 16'($urandom); pw = 24'($urandom);
    do_start(id, pw, e);
    build_expected(e, id, pw, 1);
    wait_until(e + SEQ + 2);
    checks++;
    if (pT.size() - base != eT.size()) begin
      failures++; $display("FAIL midreset_pulse_count: got %0d expected %0d", pT.size() - base, eT.size());
    end
    for (int i = 0; i < eT.size(); i++) begin
      int gt; logic [3:0] gd;
      gt = (base + i < pT.size()) ? pT[base + i] : -1;
      gd = (base + i < pT.size()) ? pD[base + i] : 4'hx;
      checks++;
      if (gt != eT[i] || gd !== eD[i]) begin
        failures++; $display("FAIL midreset_pulse[%0d]: got t=%0d d=%h expected t=%0d d=%h", i, gt - e, gd, eT[i] - e, eD[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ignored_and_race();
    logic [15:0] id; logic [23:0] pw; logic [2:0] pid;
    int e, base, base2, lc0;
    id = 16'($urandom); pw = 24'($urandom); pid = 3'($urandom_range(1, 7));
    lc0 = logoutCnt;
    base = pT.size();
    do_start(id, pw, e);
    build_expected(e, id, pw, 1);
    wait_until(e + 50);
    logout_req = 1'b1;
    @(negedge clk);
    logout_req = 1'b0;
    wait_until(e + 95);
    start = 1'b1; id_in = ~id; pswd_in = ~pw;
    @(negedge clk);
    start = 1'b0;
    wait_until(e + SEQ + TMO - 1);
    checks++;
    if (fail !== 1'b0 || logged_in !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL race_pre: got fail=%b li=%b busy=%b expected 0 0 1", fail, logged_in, busy);
    end
    LoggedIn = 1'b1; PlayerID = pid;
    @(negedge clk);
    checks++;
    if (logged_in !== 1'b1 || fail !== 1'b0 || busy !== 1'b0 || player_id !== pid) begin
      failures++;
      $display("FAIL race_login: got li=%b fail=%b busy=%b pid=%0d expected 1 0 0 %0d", logged_in, fail, busy, player_id, pid);
    end
    checks++;
    if (pT.size() - base != eT.size()) begin
      failures++; $display("FAIL ignored_pulse_count: got %0d expected %0d", pT.size() - base, eT.size());
    end
    for (int i = 0; i < eT.size(); i++) begin
      int gt; logic [3:0] gd;
      gt = (base + i < pT.size()) ? pT[base + i] : -1;
      gd = (base + i < pT.size()) ? pD[base + i] : 4'hx;
      checks++;
      if (gt != eT[i] || gd !== eD[i]) begin
        failures++; $display("FAIL ignored_pulse[%0d]: got t=%0d d=%h expected t=%0d d=%h", i, gt - e, gd, eT[i] - e, eD[i]);
      end
    end
    checks++;
    if (logoutCnt != lc0) begin failures++; $display("FAIL ignored_logout: got %0d pulses expected 0", logoutCnt - lc0); end
    base2 = pT.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (logged_in !== 1'b1 || pT.size() != base2) begin
      failures++; $display("FAIL logged_start_ignored: got li=%b pulses=%0d expected 1 0", logged_in, pT.size() - base2);
    end
    LoggedIn = 1'b0;
    @(negedge clk);
    checks++;
    if (logged_in !== 1'b0 || busy !== 1'b0 || player_id !== pid) begin
      failures++; $display("FAIL drop_to_idle: got li=%b busy=%b pid=%0d expected 0 0 %0d", logged_in, busy, player_id, pid);
    end
  endtask

  initial begin
    logic [2:0] pid2;
    pid2 = 3'($urandom_range(1, 7));
    test_reset();
    test_login(16'h5973, 24'hA04A54, 3'd2, 10);
    test_logout(3'd2);
    test_login(16'($urandom), 24'($urandom), pid2, $urandom_range(0, 62));
    test_logout(pid2);
    test_timeout();
    test_reset_mid_send();
    test_ignored_and_race();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
